alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Multi-cycle execution unit on the consuming end of the 5-bit alucontrol interface produced by the ALU decoder.
- Sits in the execute stage of the MIPS datapath and accepts an operation via a start handshake.
- Single-cycle ops finish in 1 cycle; SLLV is executed iteratively, one bit-shift per cycle.
- Registered result, zero, movz_we and illegal flags are presented with a one-cycle done pulse.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8 and at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- alucontrol  input  5  operation code, sampled at accept.
- a  input  WIDTH  operand A (rs), sampled at accept.
- b  input  WIDTH  operand B (rt/immediate), sampled at accept.
- busy  output  1  high from cycle after accept through the done cycle inclusive.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  output  WIDTH  registered result; held until the next done.
- zero  output  1  registered (result==0), updated with result.
- movz_we  output  1  MOVZ write-enable, (b==0); 0 for all other ops.
- illegal  output  1  alucontrol not in the legal set.

Behaviour:
- Reset (async, any state, aborts in-flight op): IDLE, result=0, zero=1, done=0, busy=0, movz_we=0, illegal=0, shift counter=0.
- Ops (a, b latched at accept):
  - 00000 AND: a&b.
  - 00001 OR: a|b.
  - 00010 ADD: a+b, modulo 2^WIDTH, no overflow trap.
  - 10010 SUB: a-b, modulo 2^WIDTH.
  - 10011 SLT: signed a<b ? 1 : 0.
  - 00111 BLT: same as SLT; branch taken iff zero=0.
  - 00101 LHU: a+b (address calculation only).
  - 01000 LI: b.
  - 00100 MOVZ: result=a, movz_we=(b==0).
  - 01001 MIX4: nibbles alternate from MSB downward, a then b. For WIDTH=32: {a[31:28],b[27:24],a[23:20],b[19:16],a[15:12],b[11:8],a[7:4],b[3:0]}.
  - 00110 SLLV: b << a[SHW-1:0], zero fill.
- Illegal code: result=0, zero=1, illegal=1, latency 1.
- FSM states IDLE, SHIFT, DONE:
  - IDLE & start & SLLV & shamt!=0: go to SHIFT; load working register=b, counter=shamt.
  - IDLE & start, any other case: compute combinationally, register into result, go to DONE.
  - SHIFT: each cycle working<<=1 and counter-=1. When counter reaches 1, write final value to result and go to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE.
- Latency (start sampled high at edge t):
  - Non-SLLV: done high in cycle t+1.
  - SLLV with shamt n: done in cycle t+1+n; shamt=0 gives t+1, max t+WIDTH.
- Handshake:
  - start while busy=1 is ignored; no queueing, operands not sampled.
  - Earliest next accept is the cycle after done.
  - start high in IDLE for consecutive cycles yields one op per accept. Hold-high re-accepts on the first IDLE cycle after done.
- Flags: movz_we and illegal are updated only at done, alongside result. Between ops, all outputs hold.
- Inputs a, b and alucontrol may change freely after accept without affecting the in-flight op.

Decomposition:
- Package alu_pkg holds:
  - localparams for all 11 alucontrol codes listed above.
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t.
- One sub-module, alu_comb: purely combinational single-cycle op evaluator (all ops except the SLLV iteration). Outputs value, movz_we and illegal.
- alu_mc owns the FSM, operand registers, shift counter/working register and output registers.

Test Plan:
- ADD a=0x7FFF_FFFF, b=1 -> done at t+1, result=0x8000_0000, zero=0, illegal=0, busy high only in the done cycle.
- SLT a=0xFFFF_FFFF, b=0 -> result=1. BLT a=5, b=3 -> result=0, zero=1. SUB a=3, b=3 -> zero=1.
- SLLV a=4, b=0x0000_000F -> done at t+5, result=0xF0. Also a=0 -> done at t+1, result=b. Also a=31, b=1 -> done at t+32, result=0x8000_0000.
- MIX4 a=0xAAAA_AAAA, b=0x5555_5555 -> result=0xA5A5_A5A5.
- MOVZ a=0x1234, b=0 -> result=0x1234, movz_we=1. Then b=1 -> movz_we=0. Code 5'b11111 -> illegal=1, result=0.
- Robustness:
  - start pulsed during SLLV shift -> ignored, result unaffected.
  - reset asserted mid-SHIFT -> all outputs go to reset values immediately (async), FSM returns to IDLE, no done pulse.
  - New ADD accepted after reset -> completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b10010;
  localparam logic [4:0] OP_SLT  = 5'b10011;
  localparam logic [4:0] OP_BLT  = 5'b00111;
  localparam logic [4:0] OP_LHU  = 5'b00101;
  localparam logic [4:0] OP_LI   = 5'b01000;
  localparam logic [4:0] OP_MOVZ = 5'b00100;
  localparam logic [4:0] OP_MIX4 = 5'b01001;
  localparam logic [4:0] OP_SLLV = 5'b00110;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } alu_state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle op evaluator; SLLV here only covers the zero-shift case.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] value,
  output logic             movz_we,
  output logic             illegal
);

  logic [WIDTH-1:0] mix;
  logic             lt;

  // odd nibbles (counting from LSB) come from a, so the top nibble is a's
  always_comb begin
    mix = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      mix[i*4 +: 4] = (i % 2 == 1) ? a[i*4 +: 4] : b[i*4 +: 4];
    end
  end

  assign lt = $signed(a) < $signed(b);

  always_comb begin
    value   = '0;
    movz_we = 1'b0;
    illegal = 1'b0;
    unique case (alucontrol)
      OP_AND:  value = a & b;
      OP_OR:   value = a | b;
      OP_ADD:  value = a + b;
      OP_SUB:  value = a - b;
      OP_SLT:  value = {{(WIDTH-1){1'b0}}, lt};
      OP_BLT:  value = {{(WIDTH-1){1'b0}}, lt};
      OP_LHU:  value = a + b;
      OP_LI:   value = b;
      OP_MOVZ: begin
        value   = a;
        movz_we = (b == '0);
      end
      OP_MIX4: value = mix;
      OP_SLLV: value = b;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute unit: one-cycle ops plus bit-serial SLLV,
// with registered result/flags and a one-cycle done pulse.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             movz_we,
  output logic             illegal
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             movz_q, movz_d;
  logic             ill_q, ill_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] c_value;
  logic             c_movz;
  logic             c_ill;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] work_sh;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .alucontrol(alucontrol),
    .a         (a),
    .b         (b),
    .value     (c_value),
    .movz_we   (c_movz),
    .illegal   (c_ill)
  );

  assign shamt   = a[SHW-1:0];
  assign work_sh = work_q << 1;

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    movz_d   = movz_q;
    ill_d    = ill_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (alucontrol == OP_SLLV && shamt != '0) begin
            state_d = SHIFT;
            work_d  = b;
            cnt_d   = shamt;
          end else begin
            state_d  = DONE;
            result_d = c_value;
            zero_d   = (c_value == '0);
            movz_d   = c_movz;
            ill_d    = c_ill;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = work_sh;
        cnt_d  = cnt_q - SHW'(1);
        // last step lands the shifted value straight in result
        if (cnt_q == SHW'(1)) begin
          state_d  = DONE;
          result_d = work_sh;
          zero_d   = (work_sh == '0);
          movz_d   = 1'b0;
          ill_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      movz_q   <= 1'b0;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      movz_q   <= movz_d;
      ill_q    <= ill_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign movz_we = movz_q;
  assign illegal = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Vector table plus scoreboard bench for alu_mc.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  alucontrol;
  logic [31:0] a, b;
  logic        busy, done, zero, movz_we, illegal;
  logic [31:0] result;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alucontrol(alucontrol),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .movz_we   (movz_we),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        mw;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   acc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic [4:0] op,
                              input logic [31:0] av, input logic [31:0] bv,
                              input logic [31:0] r, input logic z,
                              input logic mw, input logic il, input int lat);
    vec_t v;
    v.name = nm; v.op = op; v.a = av; v.b = bv;
    v.res = r; v.z = z; v.mw = mw; v.il = il; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // caller is at a negedge; leaves start low after accept and scrambles inputs
  task automatic drive(input vec_t v);
    alucontrol = v.op; a = v.a; b = v.b; start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    a = $urandom; b = $urandom; alucontrol = 5'($urandom);
  endtask

  task automatic finish_op();
    vec_t e;
    bit   got = 0;
    bit   busy_ok = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      if (!busy) busy_ok = 0;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      chk({e.name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({e.name, "_lat"}, 32'(cyc - acc + 1), 32'(e.lat));
    chk({e.name, "_res"}, result, e.res);
    chk({e.name, "_zero"}, 32'(zero), 32'(e.z));
    chk({e.name, "_movz"}, 32'(movz_we), 32'(e.mw));
    chk({e.name, "_ill"}, 32'(illegal), 32'(e.il));
    chk({e.name, "_busy"}, 32'({busy_ok, busy}), 32'b11);
    @(negedge clk);
    chk({e.name, "_idle"}, 32'({busy, done}), 32'b00);
  endtask

  task automatic run_op(input vec_t v);
    drive(v);
    finish_op();
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_res"}, result, 32'h0);
    chk({nm, "_flags"}, 32'({zero, done, busy, movz_we, illegal}),
        32'b10000);
  endtask

  initial begin
    vec_t v;
    bit   quiet;
    reset = 1'b1; start = 1'b0; alucontrol = '0; a = '0; b = '0;

    add("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 0, 1);
    add("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'h0, 32'h1, 0, 0, 0, 1);
    add("blt_nt", OP_BLT, 32'd5, 32'd3, 32'h0, 1, 0, 0, 1);
    add("blt_t", OP_BLT, 32'hFFFF_FFFE, 32'd3, 32'h1, 0, 0, 0, 1);
    add("sub_eq", OP_SUB, 32'd3, 32'd3, 32'h0, 1, 0, 0, 1);
    add("sub_wrap", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 1);
    add("and", OP_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 0, 0, 0, 1);
    add("or", OP_OR, 32'h0F00_00F0, 32'h1000_0001, 32'h1F00_00F1, 0, 0, 0, 1);
    add("lhu", OP_LHU, 32'h1000, 32'h20, 32'h1020, 0, 0, 0, 1);
    add("li", OP_LI, 32'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0, 1);
    add("movz_w", OP_MOVZ, 32'h1234, 32'h0, 32'h1234, 0, 1, 0, 1);
    add("movz_nw", OP_MOVZ, 32'h1234, 32'h1, 32'h1234, 0, 0, 0, 1);
    add("mix_a5", OP_MIX4, 32'hAAAA_AAAA, 32'h5555_5555, 32'hA5A5_A5A5, 0, 0, 0, 1);
    add("mix_seq", OP_MIX4, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1A3C_5E70, 0, 0, 0, 1);
    add("ill_1f", 5'b11111, 32'd5, 32'd6, 32'h0, 1, 0, 1, 1);
    add("ill_0a", 5'b01010, 32'd5, 32'd6, 32'h0, 1, 0, 1, 1);
    add("sllv_4", OP_SLLV, 32'd4, 32'hF, 32'hF0, 0, 0, 0, 5);
    add("sllv_0", OP_SLLV, 32'd0, 32'h1234_5678, 32'h1234_5678, 0, 0, 0, 1);
    add("sllv_31", OP_SLLV, 32'd31, 32'h1, 32'h8000_0000, 0, 0, 0, 32);
    add("sllv_hi", OP_SLLV, 32'h24, 32'h3, 32'h30, 0, 0, 0, 5);
    add("sllv_out", OP_SLLV, 32'd1, 32'h8000_0000, 32'h0, 1, 0, 0, 2);

    repeat (2) @(negedge clk);
    check_reset_vals("rst_in");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_out");

    foreach (vecs[i]) run_op(vecs[i]);

    // start pulse while shifting must be ignored
    v = '{"sllv_pulse", OP_SLLV, 32'd8, 32'h3, 32'h300, 0, 0, 0, 9};
    drive(v);
    repeat (3) @(negedge clk);
    start = 1'b1; alucontrol = OP_ADD; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    finish_op();
    quiet = 1;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) quiet = 0;
    end
    chk("pulse_no_extra", 32'(quiet), 32'd1);

    // start held high: re-accept on the first IDLE cycle after done
    v = '{"hold1", OP_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1};
    alucontrol = v.op; a = v.a; b = v.b; start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    acc = cyc;
    begin
      vec_t e;
      @(negedge clk);
      e = sb.pop_front();
      chk("hold1_done", 32'(done), 32'd1);
      chk("hold1_res", result, e.res);
    end
    v = '{"hold2", OP_SUB, 32'd10, 32'd4, 32'd6, 0, 0, 0, 1};
    alucontrol = v.op; a = v.a; b = v.b;
    sb.push_back(v);
    @(posedge clk); #1;
    chk("hold_idle", 32'({busy, done}), 32'b00);
    @(posedge clk); #1;
    acc = cyc;
    start = 1'b0;
    finish_op();

    // async reset in the middle of a shift
    vecs[10].name = "movz_pre";
    run_op(vecs[10]);
    v = '{"sllv_abort", OP_SLLV, 32'd20, 32'h1, 32'h0010_0000, 0, 0, 0, 21};
    drive(v);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    quiet = 1;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) quiet = 0;
    end
    chk("rst_no_done", 32'(quiet), 32'd1);
    check_reset_vals("rst_after");

    v = '{"add_post", OP_ADD, 32'd5, 32'd6, 32'd11, 0, 0, 0, 1};
    run_op(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
